// File: rtl/ublfs_pipe_11_0.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ublfs_pipe_11_0
// Brief    : Three-stage valid/ready subtractor D = X - Y built as X + ~Y + 1
//            on a Ladner-Fischer prefix carry network, with borrow and signed
//            overflow outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ublfs_pipe_11_0 #(
    parameter int WIDTH = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             OV
);

    localparam int c_levels = $clog2(WIDTH);
    localparam int c_split  = (c_levels + 1) / 2;

    // One prefix level: node i with bit (k-1) set absorbs the group ending
    // just below its aligned 2^(k-1) block, giving odd pairing at level 1.
    function automatic logic [2*WIDTH-1:0] lf_level(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input int               k
    );
        logic [WIDTH-1:0] g_o;
        logic [WIDTH-1:0] p_o;
        int               j;
        g_o = g;
        p_o = p;
        for (int i = 0; i < WIDTH; i++) begin
            if (((i >> (k - 1)) & 1) == 1) begin
                j      = ((i >> (k - 1)) << (k - 1)) - 1;
                g_o[i] = g[i] | (p[i] & g[j]);
                p_o[i] = p[i] & p[j];
            end
        end
        return {g_o, p_o};
    endfunction

    logic             r_v1;
    logic             r_v2;
    logic             r_v3;
    logic             w_adv1;
    logic             w_adv2;
    logic             w_adv3;

    logic [WIDTH-1:0] r_s1_g;
    logic [WIDTH-1:0] r_s1_p;
    logic             r_s1_xm;
    logic             r_s1_ym;

    logic [WIDTH-1:0] r_s2_g;
    logic [WIDTH-1:0] r_s2_p;
    logic [WIDTH-1:0] r_s2_p0;
    logic             r_s2_xm;
    logic             r_s2_ym;

    logic [WIDTH-1:0] w_ga;
    logic [WIDTH-1:0] w_pa;
    logic [WIDTH-1:0] w_gb;
    logic [WIDTH-1:0] w_pb;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_d;
    logic             w_bo;
    logic             w_ov;

    logic [WIDTH-1:0] r_d;
    logic             r_bo;
    logic             r_ov;

    assign w_adv3   = ~r_v3 | OUT_READY;
    assign w_adv2   = ~r_v2 | w_adv3;
    assign w_adv1   = ~r_v1 | w_adv2;
    assign IN_READY = w_adv1;

    always_comb begin
        w_ga = r_s1_g;
        w_pa = r_s1_p;
        for (int k = 1; k <= c_split; k++) begin
            {w_ga, w_pa} = lf_level(w_ga, w_pa, k);
        end
    end

    always_comb begin
        w_gb = r_s2_g;
        w_pb = r_s2_p;
        for (int k = c_split + 1; k <= c_levels; k++) begin
            {w_gb, w_pb} = lf_level(w_gb, w_pb, k);
        end
    end

    // Carry-in is the constant 1 of the two's-complement negation.
    always_comb begin
        w_c[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_c[i+1] = w_gb[i] | w_pb[i];
        end
        w_d  = r_s2_p0 ^ w_c[WIDTH-1:0];
        w_bo = ~w_c[WIDTH];
        w_ov = (r_s2_xm ^ r_s2_ym) & (w_d[WIDTH-1] ^ r_s2_xm);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v1 <= 1'b0;
        end else if (w_adv1) begin
            r_v1 <= IN_VALID;
            if (IN_VALID) begin
                r_s1_g  <= X & ~Y;
                r_s1_p  <= X ^ ~Y;
                r_s1_xm <= X[WIDTH-1];
                r_s1_ym <= Y[WIDTH-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v2 <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_g  <= w_ga;
                r_s2_p  <= w_pa;
                r_s2_p0 <= r_s1_p;
                r_s2_xm <= r_s1_xm;
                r_s2_ym <= r_s1_ym;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v3 <= 1'b0;
            r_d  <= '0;
            r_bo <= 1'b0;
            r_ov <= 1'b0;
        end else if (w_adv3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_d  <= w_d;
                r_bo <= w_bo;
                r_ov <= w_ov;
            end
        end
    end

    assign OUT_VALID = r_v3;
    assign D         = r_d;
    assign BO        = r_bo;
    assign OV        = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_ublfs_pipe_11_0.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ublfs_pipe_11_0
// Brief    : Directed and randomized checks of the pipelined LF subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ublfs_pipe_11_0;

    localparam int WIDTH = 12;

    logic             r_clk = 1'b0;
    logic             r_rst;
    logic             r_in_valid;
    logic             w_in_ready;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             w_out_valid;
    logic             r_out_ready;
    logic [WIDTH-1:0] w_d;
    logic             w_bo;
    logic             w_ov;

    int checks = 0;
    int errors = 0;

    always #5 r_clk = ~r_clk;

    ublfs_pipe_11_0 #(.WIDTH(WIDTH)) dut (
        .CLK       (r_clk),
        .RST       (r_rst),
        .IN_VALID  (r_in_valid),
        .IN_READY  (w_in_ready),
        .X         (r_x),
        .Y         (r_y),
        .OUT_VALID (w_out_valid),
        .OUT_READY (r_out_ready),
        .D         (w_d),
        .BO        (w_bo),
        .OV        (w_ov)
    );

    task automatic test_reset();
        r_rst = 1'b1; r_in_valid = 1'b0; r_out_ready = 1'b0; r_x = '0; r_y = '0;
        repeat (3) @(negedge r_clk);
        checks++;
        if (w_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", w_out_valid); end
        checks++;
        if ({w_d, w_bo, w_ov} !== 14'h0) begin errors++; $display("FAIL reset_outputs got d=%h bo=%b ov=%b want 0 0 0", w_d, w_bo, w_ov); end
        r_rst = 1'b0;
        #1;
        checks++;
        if (w_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", w_in_ready); end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] xs  [5] = '{12'h005, 12'h003, 12'h800, 12'h7FF, 12'hABC};
        logic [WIDTH-1:0] ys  [5] = '{12'h003, 12'h005, 12'h001, 12'hFFF, 12'hABC};
        logic [WIDTH-1:0] eds [5] = '{12'h002, 12'hFFE, 12'h7FF, 12'h800, 12'h000};
        logic             ebo [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic             eov [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int               lat;
        for (int t = 0; t < 5; t++) begin
            @(negedge r_clk);
            r_in_valid = 1'b1; r_x = xs[t]; r_y = ys[t]; r_out_ready = 1'b1;
            #1;
            checks++;
            if (w_in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready[%0d] got %b want 1", t, w_in_ready); end
            @(posedge r_clk);
            lat = 0;
            do begin
                @(negedge r_clk);
                r_in_valid = 1'b0;
                lat++;
            end while (!w_out_valid && lat < 8);
            checks++;
            if (lat != 3) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 3", t, lat); end
            checks++;
            if ({w_d, w_bo, w_ov} !== {eds[t], ebo[t], eov[t]})
                begin errors++; $display("FAIL basic_result[%0d] got d=%h bo=%b ov=%b want d=%h bo=%b ov=%b", t, w_d, w_bo, w_ov, eds[t], ebo[t], eov[t]); end
        end
        @(negedge r_clk);
    endtask

    task automatic test_backpressure();
        int k = 0;
        int nout = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge r_clk);
            r_out_ready = (c >= 8);
            r_in_valid  = (k < 6);
            r_x = 12'h100 + 12'(k);
            r_y = 12'(k);
            #1;
            if (c >= 3 && c < 8) begin
                checks++;
                if (w_in_ready !== 1'b0 || k != 3) begin errors++; $display("FAIL bp_full c=%0d got in_ready=%b accepted=%0d want 0 3", c, w_in_ready, k); end
            end
            if (c == 7) begin
                checks++;
                if (w_out_valid !== 1'b1 || w_d !== 12'h100) begin errors++; $display("FAIL bp_stable got v=%b d=%h want 1 100", w_out_valid, w_d); end
            end
            if (c == 8) begin
                checks++;
                if (w_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_emit got %b want 1", w_in_ready); end
            end
            if (w_out_valid && r_out_ready) begin
                checks++;
                if ({w_d, w_bo, w_ov} !== {12'h100, 1'b0, 1'b0} || c != 8 + nout)
                    begin errors++; $display("FAIL bp_out[%0d] got d=%h bo=%b ov=%b cyc=%0d want d=100 bo=0 ov=0 cyc=%0d", nout, w_d, w_bo, w_ov, c, 8 + nout); end
                nout++;
            end
            if (r_in_valid && w_in_ready) k++;
        end
        checks++;
        if (nout != 6) begin errors++; $display("FAIL bp_count got %0d want 6", nout); end
    endtask

    task automatic test_reset_midstream();
        r_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge r_clk);
            r_in_valid = 1'b1; r_x = 12'(k + 1); r_y = '0;
        end
        @(negedge r_clk);
        checks++;
        if (w_out_valid !== 1'b1 || w_in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_full got v=%b rdy=%b want 1 0", w_out_valid, w_in_ready); end
        r_rst = 1'b1; r_in_valid = 1'b1; r_x = 12'h555;
        @(negedge r_clk);
        r_rst = 1'b0; r_in_valid = 1'b0;
        #1;
        checks++;
        if (w_out_valid !== 1'b0 || w_d !== 12'h000 || w_in_ready !== 1'b1)
            begin errors++; $display("FAIL rst_mid_flush got v=%b d=%h rdy=%b want 0 000 1", w_out_valid, w_d, w_in_ready); end
        r_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge r_clk);
            checks++;
            if (w_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale c=%0d got v=%b d=%h want v=0", c, w_out_valid, w_d); end
        end
    endtask

    task automatic test_random();
        logic [37:0]      q[$];
        logic [37:0]      e;
        logic [WIDTH-1:0] ed;
        int               diff;
        int               accepted = 0;
        int               got = 0;
        int               cyc = 0;
        while (got < 10000 && cyc < 60000) begin
            @(negedge r_clk);
            cyc++;
            r_in_valid  = (accepted < 10000) && ($urandom_range(0, 3) != 0);
            r_x         = 12'($urandom);
            r_y         = 12'($urandom);
            r_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (w_out_valid && r_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra got d=%h with nothing outstanding", w_d);
                end else begin
                    e = q.pop_front();
                    if ({w_d, w_bo, w_ov} !== e[13:0])
                        begin errors++; $display("FAIL rand[%0d] x=%h y=%h got d=%h bo=%b ov=%b want d=%h bo=%b ov=%b", got, e[37:26], e[25:14], w_d, w_bo, w_ov, e[13:2], e[1], e[0]); end
                end
                got++;
            end
            if (r_in_valid && w_in_ready) begin
                diff = int'(r_x) - int'(r_y);
                ed   = diff[11:0];
                q.push_back({r_x, r_y, ed, (r_x < r_y), (r_x[11] != r_y[11]) && (ed[11] != r_x[11])});
                accepted++;
            end
        end
        checks++;
        if (got != 10000 || q.size() != 0) begin errors++; $display("FAIL rand_count got %0d left %0d want 10000 0", got, q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
